// File: rtl/data_extractor_for_store.sv
// data_extractor_for_store: registered RV32I store-data formatter producing zero-extended write data and byte mask
module data_extractor_for_store #(
  parameter logic [6:0] STORE_OPCODE = 7'b0100011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst,
  input  logic [31:0] data,
  output logic [31:0] y,
  output logic [3:0]  wmask
);
  logic        is_store;
  logic [2:0]  funct3;
  logic [3:0]  wmask_d;
  logic [31:0] y_d;
  always_comb begin
    is_store = inst[6:0] == STORE_OPCODE;
    funct3   = inst[14:12];
    wmask_d  = !is_store      ? 4'b0000 :
               funct3 == 3'd0 ? 4'b0001 :
               funct3 == 3'd1 ? 4'b0011 :
               funct3 == 3'd2 ? 4'b1111 : 4'b0000;
    // expanding the byte mask to a bit mask yields the zero extension directly
    y_d      = data & {{8{wmask_d[3]}}, {8{wmask_d[2]}}, {8{wmask_d[1]}}, {8{wmask_d[0]}}};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      y     <= 32'h0;
      wmask <= 4'b0000;
    end else begin
      y     <= y_d;
      wmask <= wmask_d;
    end
endmodule

// File: tb/tb_data_extractor_for_store.sv
// tb_data_extractor_for_store: directed vectors checked against a byte-count model and literal expectations
module tb_data_extractor_for_store;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] inst = 32'h0;
  logic [31:0] data = 32'h0;
  logic [31:0] y;
  logic [3:0]  wmask;
  logic [31:0] exp_y = 32'h0;
  logic [3:0]  exp_m = 4'h0;
  int tests = 0;
  int fails = 0;

  data_extractor_for_store dut (.clk(clk), .reset(reset), .inst(inst), .data(data), .y(y), .wmask(wmask));

  always #5 clk = ~clk;

  function automatic int store_bytes(input logic [31:0] i);
    if (i[6:0] != 7'b0100011) return 0;
    if (i[14:12] == 3'd0) return 1;
    if (i[14:12] == 3'd1) return 2;
    if (i[14:12] == 3'd2) return 4;
    return 0;
  endfunction

  function automatic logic [35:0] model(input logic [31:0] i, input logic [31:0] d);
    int n;
    longint unsigned keep;
    n = store_bytes(i);
    keep = (64'd1 << (8 * n)) - 64'd1;
    return {4'((1 << n) - 1), 32'(longint'(d) & keep)};
  endfunction

  always @(posedge clk or posedge reset)
    if (reset) {exp_m, exp_y} <= 36'h0;
    else {exp_m, exp_y} <= model(inst, data);

  task automatic chk(input string name, input logic [31:0] ey, input logic [3:0] em);
    tests++;
    if (y !== ey || wmask !== em) begin
      fails++;
      $display("FAIL %s: y=%h wmask=%b, required y=%h wmask=%b", name, y, wmask, ey, em);
    end
  endtask

  always @(negedge clk) if (!reset) chk("model", exp_y, exp_m);

  task automatic apply(input logic [31:0] i, input logic [31:0] d);
    @(negedge clk);
    inst = i;
    data = d;
  endtask

  task automatic step_chk(input string name, input logic [31:0] i, input logic [31:0] d,
                          input logic [31:0] ey, input logic [3:0] em);
    apply(i, d);
    @(posedge clk);
    #1 chk(name, ey, em);
  endtask

  initial begin
    inst = 'x;
    data = 'x;
    #1 reset = 1'b1;
    #1 chk("reset_init", 32'h0, 4'b0000);
    inst = 32'h0050_2023;
    data = 32'hA5F0B376;
    @(posedge clk);
    #1 chk("reset_hold", 32'h0, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 chk("first_after_reset", 32'hA5F0B376, 4'b1111);
    step_chk("sb", 32'h0050_0023, 32'hA5F0B376, 32'h0000_0076, 4'b0001);
    step_chk("sh", 32'h0050_1023, 32'hA5F0B376, 32'h0000_B376, 4'b0011);
    step_chk("sw", 32'h0050_2023, 32'hA5F0B376, 32'hA5F0B376, 4'b1111);
    step_chk("invalid_ff", 32'hFFFF_FFFF, 32'hA5F0B376, 32'h0, 4'b0000);
    step_chk("lb_opcode", 32'h0050_0003, 32'hFFFF_FFFF, 32'h0, 4'b0000);
    step_chk("store_f3_011", 32'h0050_3023, 32'hFFFF_FFFF, 32'h0, 4'b0000);
    step_chk("store_f3_100", 32'h0050_4023, 32'hFFFF_FFFF, 32'h0, 4'b0000);
    step_chk("store_f3_111", 32'h0050_7023, 32'hFFFF_FFFF, 32'h0, 4'b0000);
    step_chk("sb_other_fields", 32'hFFF0_8FA3, 32'hCAFE_BABE, 32'h0000_00BE, 4'b0001);
    step_chk("sh_other_fields", 32'hABCD_9123, 32'hCAFE_BABE, 32'h0000_BABE, 4'b0011);
    step_chk("b2b_sb", 32'h0050_0023, 32'h1234_5678, 32'h0000_0078, 4'b0001);
    step_chk("b2b_sh", 32'h0050_1023, 32'h1234_5678, 32'h0000_5678, 4'b0011);
    step_chk("b2b_sw", 32'h0050_2023, 32'h1234_5678, 32'h1234_5678, 4'b1111);
    apply(32'h0050_0023, 32'h0000_00FF);
    #1 chk("latency_hold", 32'h1234_5678, 4'b1111);
    @(posedge clk);
    #1 chk("latency_load", 32'h0000_00FF, 4'b0001);
    apply(32'h0050_2023, 32'hDEAD_BEEF);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("reset_midstream", 32'h0, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    apply(32'h0000_0013, 32'hDEAD_BEEF);
    @(posedge clk);
    #1 chk("after_reset_nonstore", 32'h0, 4'b0000);
    for (int k = 0; k < 16; k++) apply({$urandom} | 32'h23, $urandom);
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, required completion before 20000");
    $fatal(1);
  end
endmodule
